// File: rtl/key_conditioner_if.sv
// Push-button bundle between the key conditioner and its user: raw active-low
// key levels in, debounced level plus press/long/repeat strobes out.
`timescale 1ns/1ps

interface key_conditioner_if #(
    parameter int N_KEYS = 3
);
    logic [N_KEYS-1:0] key_n;
    logic [N_KEYS-1:0] key_state;
    logic [N_KEYS-1:0] key_pulse;
    logic [N_KEYS-1:0] key_long;
    logic [N_KEYS-1:0] key_rep;

    modport master (
        output key_n,
        input  key_state,
        input  key_pulse,
        input  key_long,
        input  key_rep
    );

    modport slave (
        input  key_n,
        output key_state,
        output key_pulse,
        output key_long,
        output key_rep
    );
endinterface

// File: rtl/key_conditioner.sv
// Multi-channel push-button conditioner: synchronizes, debounces on a shared
// millisecond tick, and flags accepted presses, long presses and auto-repeat.
`timescale 1ns/1ps

module key_conditioner #(
    parameter int N_KEYS   = 3,
    parameter int TICK_CYC = 25000,
    parameter int DEB_MS   = 20,
    parameter int LONG_MS  = 1000,
    parameter int REP_MS   = 200
) (
    input logic               clk_in,
    input logic               rst_in,
    key_conditioner_if.slave  bus
);
    localparam int TW = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYC - 1);
    localparam logic [15:0]   DEB_T     = 16'(DEB_MS);
    localparam logic [15:0]   LONG_T    = 16'(LONG_MS);
    localparam logic [15:0]   REP_T     = 16'(REP_MS);
    localparam bit            REP_EN    = (REP_MS != 0);

    typedef enum logic [2:0] {
        IDLE,
        PRESS_DEB,
        HELD,
        LONG,
        REL_DEB
    } key_fsm_t;

    logic [N_KEYS-1:0] sync1;
    logic [N_KEYS-1:0] sync2;
    logic [N_KEYS-1:0] s;
    logic [TW-1:0]     tick_cnt;
    logic              tick;

    key_fsm_t          state      [N_KEYS];
    key_fsm_t          state_nx   [N_KEYS];
    logic [15:0]       cnt        [N_KEYS];
    logic [15:0]       cnt_nx     [N_KEYS];
    logic [15:0]       cnt_inc    [N_KEYS];
    logic [N_KEYS-1:0] long_flag;
    logic [N_KEYS-1:0] long_flag_nx;
    logic [N_KEYS-1:0] state_on_nx;
    logic [N_KEYS-1:0] pulse_nx;
    logic [N_KEYS-1:0] long_nx;
    logic [N_KEYS-1:0] rep_nx;
    logic [N_KEYS-1:0] key_state_q;
    logic [N_KEYS-1:0] pulse_q;
    logic [N_KEYS-1:0] long_q;
    logic [N_KEYS-1:0] rep_q;

    // Idle-high synchronizers so a reset never looks like a press.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            sync1 <= '1;
            sync2 <= '1;
        end else begin
            sync1 <= bus.key_n;
            sync2 <= sync1;
        end
    end

    assign s = ~sync2;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
        end
    end

    assign tick = (tick_cnt == TICK_LAST);

    // A level change always restarts the count, so it is tested before the tick.
    always_comb begin
        for (int i = 0; i < N_KEYS; i++) begin
            state_nx[i]     = state[i];
            cnt_nx[i]       = cnt[i];
            cnt_inc[i]      = (cnt[i] == 16'hFFFF) ? cnt[i] : cnt[i] + 16'd1;
            long_flag_nx[i] = long_flag[i];
            pulse_nx[i]     = 1'b0;
            long_nx[i]      = 1'b0;
            rep_nx[i]       = 1'b0;
            case (state[i])
                IDLE: begin
                    if (s[i]) begin
                        state_nx[i] = PRESS_DEB;
                        cnt_nx[i]   = '0;
                    end
                end
                PRESS_DEB: begin
                    if (!s[i]) begin
                        state_nx[i] = IDLE;
                        cnt_nx[i]   = '0;
                    end else if (tick) begin
                        if (cnt_inc[i] >= DEB_T) begin
                            state_nx[i]     = HELD;
                            cnt_nx[i]       = '0;
                            long_flag_nx[i] = 1'b0;
                            pulse_nx[i]     = 1'b1;
                        end else begin
                            cnt_nx[i] = cnt_inc[i];
                        end
                    end
                end
                HELD: begin
                    if (!s[i]) begin
                        state_nx[i] = REL_DEB;
                        cnt_nx[i]   = '0;
                    end else if (tick) begin
                        if (cnt_inc[i] >= LONG_T) begin
                            state_nx[i]     = LONG;
                            cnt_nx[i]       = '0;
                            long_flag_nx[i] = 1'b1;
                            long_nx[i]      = 1'b1;
                        end else begin
                            cnt_nx[i] = cnt_inc[i];
                        end
                    end
                end
                LONG: begin
                    if (!s[i]) begin
                        state_nx[i] = REL_DEB;
                        cnt_nx[i]   = '0;
                    end else if (tick) begin
                        if (REP_EN && (cnt_inc[i] >= REP_T)) begin
                            cnt_nx[i] = '0;
                            rep_nx[i] = 1'b1;
                        end else begin
                            cnt_nx[i] = cnt_inc[i];
                        end
                    end
                end
                REL_DEB: begin
                    if (s[i]) begin
                        state_nx[i] = long_flag[i] ? LONG : HELD;
                        cnt_nx[i]   = '0;
                    end else if (tick) begin
                        if (cnt_inc[i] >= DEB_T) begin
                            state_nx[i] = IDLE;
                            cnt_nx[i]   = '0;
                        end else begin
                            cnt_nx[i] = cnt_inc[i];
                        end
                    end
                end
                default: begin
                    state_nx[i] = IDLE;
                    cnt_nx[i]   = '0;
                end
            endcase
            state_on_nx[i] = (state_nx[i] == HELD) || (state_nx[i] == LONG) ||
                             (state_nx[i] == REL_DEB);
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int i = 0; i < N_KEYS; i++) begin
                state[i] <= IDLE;
                cnt[i]   <= '0;
            end
            long_flag   <= '0;
            key_state_q <= '0;
            pulse_q     <= '0;
            long_q      <= '0;
            rep_q       <= '0;
        end else begin
            for (int i = 0; i < N_KEYS; i++) begin
                state[i] <= state_nx[i];
                cnt[i]   <= cnt_nx[i];
            end
            long_flag   <= long_flag_nx;
            key_state_q <= state_on_nx;
            pulse_q     <= pulse_nx;
            long_q      <= long_nx;
            rep_q       <= rep_nx;
        end
    end

    assign bus.key_state = key_state_q;
    assign bus.key_pulse = pulse_q;
    assign bus.key_long  = long_q;
    assign bus.key_rep   = rep_q;

endmodule

// File: tb/tb_key_conditioner.sv
// Directed bench for key_conditioner with a 4-cycle tick: press, bounce,
// glitch, long hold with repeat, simultaneous keys and reset mid-press.
`timescale 1ns/1ps

module tb_key_conditioner;
    localparam int N_KEYS   = 3;
    localparam int TICK_CYC = 4;
    localparam int DEB_MS   = 3;
    localparam int LONG_MS  = 10;
    localparam int REP_MS   = 4;

    logic clk = 1'b0;
    logic rst;

    int checks = 0;
    int errors = 0;
    int cyc;
    int pulse_cnt [N_KEYS];
    int long_cnt  [N_KEYS];
    int rep_cnt   [N_KEYS];
    int state_hi  [N_KEYS];
    int pulse_cyc [N_KEYS];
    int long_cyc  [N_KEYS];
    int rep_cyc   [8];

    key_conditioner_if #(.N_KEYS(N_KEYS)) bus ();

    key_conditioner #(
        .N_KEYS  (N_KEYS),
        .TICK_CYC(TICK_CYC),
        .DEB_MS  (DEB_MS),
        .LONG_MS (LONG_MS),
        .REP_MS  (REP_MS)
    ) dut (
        .clk_in(clk),
        .rst_in(rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic check_range(input string tag, input int observed, input int lo,
                               input int hi);
        checks++;
        assert (observed >= lo && observed <= hi)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %0d expected %0d..%0d", tag, observed, lo, hi);
        end
    endtask

    task automatic clear_counts();
        cyc = 0;
        for (int k = 0; k < N_KEYS; k++) begin
            pulse_cnt[k] = 0;
            long_cnt[k]  = 0;
            rep_cnt[k]   = 0;
            state_hi[k]  = 0;
            pulse_cyc[k] = 0;
            long_cyc[k]  = 0;
        end
        for (int r = 0; r < 8; r++) rep_cyc[r] = 0;
    endtask

    // Samples on the falling edge, away from the DUT's active edge.
    task automatic apply_stimulus(input int n);
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            cyc++;
            for (int k = 0; k < N_KEYS; k++) begin
                if (bus.key_pulse[k] === 1'b1) begin
                    if (pulse_cnt[k] == 0) pulse_cyc[k] = cyc;
                    pulse_cnt[k]++;
                end
                if (bus.key_long[k] === 1'b1) begin
                    if (long_cnt[k] == 0) long_cyc[k] = cyc;
                    long_cnt[k]++;
                end
                if (bus.key_rep[k] === 1'b1) begin
                    if (k == 2 && rep_cnt[k] < 8) rep_cyc[rep_cnt[k]] = cyc;
                    rep_cnt[k]++;
                end
                if (bus.key_state[k] === 1'b1) state_hi[k]++;
            end
        end
    endtask

    initial begin
        clear_counts();
        rst = 1'b1;
        bus.key_n = 3'b000;
        apply_stimulus(3);
        check_output("reset key_state", 32'(bus.key_state), 0);
        check_output("reset key_pulse", 32'(bus.key_pulse), 0);
        check_output("reset key_long", 32'(bus.key_long), 0);
        check_output("reset key_rep", 32'(bus.key_rep), 0);

        bus.key_n = 3'b111;
        apply_stimulus(2);
        rst = 1'b0;
        clear_counts();
        apply_stimulus(10);
        check_output("idle no pulses", 32'(pulse_cnt[0] + pulse_cnt[1] + pulse_cnt[2]), 0);

        // Clean press on key 0: 32 cycles held, then released.
        clear_counts();
        bus.key_n[0] = 1'b0;
        apply_stimulus(32);
        bus.key_n[0] = 1'b1;
        apply_stimulus(30);
        check_output("clean pulse count", pulse_cnt[0], 1);
        check_range("clean press latency", pulse_cyc[0], (DEB_MS - 1) * TICK_CYC,
                    DEB_MS * TICK_CYC + 3);
        check_output("clean state cycles", state_hi[0], 32);
        check_output("clean no long", long_cnt[0], 0);
        check_output("clean no rep", rep_cnt[0], 0);
        check_output("clean state released", 32'(bus.key_state[0]), 0);

        // Bounce on key 1: never stable for the full debounce time.
        clear_counts();
        bus.key_n[1] = 1'b0;
        apply_stimulus(8);
        bus.key_n[1] = 1'b1;
        apply_stimulus(4);
        bus.key_n[1] = 1'b0;
        apply_stimulus(8);
        bus.key_n[1] = 1'b1;
        apply_stimulus(40);
        check_output("bounce no pulse", pulse_cnt[1], 0);
        check_output("bounce state low", state_hi[1], 0);
        check_output("bounce no long", long_cnt[1], 0);
        check_output("bounce no rep", rep_cnt[1], 0);

        // Release glitch on key 0 while held.
        clear_counts();
        bus.key_n[0] = 1'b0;
        apply_stimulus(24);
        check_output("glitch first pulse", pulse_cnt[0], 1);
        clear_counts();
        bus.key_n[0] = 1'b1;
        apply_stimulus(4);
        bus.key_n[0] = 1'b0;
        apply_stimulus(20);
        check_output("glitch state held", state_hi[0], 24);
        check_output("glitch no new pulse", pulse_cnt[0], 0);
        check_output("glitch no long", long_cnt[0], 0);
        bus.key_n[0] = 1'b1;
        apply_stimulus(30);
        check_output("glitch state released", 32'(bus.key_state[0]), 0);

        // Keys 0 and 1 pressed together.
        clear_counts();
        bus.key_n = 3'b100;
        apply_stimulus(20);
        check_output("simul pulse key0", pulse_cnt[0], 1);
        check_output("simul pulse key1", pulse_cnt[1], 1);
        check_output("simul same cycle", pulse_cyc[1], pulse_cyc[0]);
        bus.key_n = 3'b111;
        apply_stimulus(30);

        // Long hold on key 2 for 30 ticks.
        clear_counts();
        bus.key_n[2] = 1'b0;
        apply_stimulus(120);
        bus.key_n[2] = 1'b1;
        apply_stimulus(40);
        check_output("long pulse count", pulse_cnt[2], 1);
        check_output("long strobe count", long_cnt[2], 1);
        check_output("long rep count", rep_cnt[2], 4);
        check_output("long after pulse", long_cyc[2] - pulse_cyc[2], LONG_MS * TICK_CYC);
        check_output("first rep spacing", rep_cyc[0] - long_cyc[2], REP_MS * TICK_CYC);
        check_output("second rep spacing", rep_cyc[1] - rep_cyc[0], REP_MS * TICK_CYC);
        check_output("fourth rep spacing", rep_cyc[3] - rep_cyc[0], 3 * REP_MS * TICK_CYC);
        check_output("long state released", 32'(bus.key_state[2]), 0);

        // Reset while key 2 is long-held, key still down afterwards.
        clear_counts();
        bus.key_n[2] = 1'b0;
        apply_stimulus(60);
        check_output("pre-reset long", long_cnt[2], 1);
        check_output("pre-reset state", 32'(bus.key_state[2]), 1);
        #2;
        rst = 1'b1;
        #1;
        check_output("async reset key_state", 32'(bus.key_state), 0);
        check_output("async reset key_pulse", 32'(bus.key_pulse), 0);
        check_output("async reset key_long", 32'(bus.key_long), 0);
        check_output("async reset key_rep", 32'(bus.key_rep), 0);
        apply_stimulus(3);
        clear_counts();
        rst = 1'b0;
        apply_stimulus(14);
        check_output("re-press pulse count", pulse_cnt[2], 1);
        check_output("re-press pulse cycle", pulse_cyc[2], 12);
        check_output("re-press no long", long_cnt[2], 0);
        bus.key_n[2] = 1'b1;
        apply_stimulus(40);
        check_output("final state idle", 32'(bus.key_state), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/key_conditioner.md
KEY_CONDITIONER -- requirements
Module: key_conditioner

Interface
REQ-001 Parameter N_KEYS, default 3: number of independent push-button channels.
REQ-002 Parameter TICK_CYC, default 25000: clk_in cycles per 1 ms tick (25 MHz).
REQ-003 Parameter DEB_MS, default 20: debounce time in ticks (press and release), range 1..65535.
REQ-004 Parameter LONG_MS, default 1000: held time in ticks after debounce before long-press, range 1..65535.
REQ-005 Parameter REP_MS, default 200: auto-repeat period in ticks while long-held; 0 disables repeat.
REQ-006 clk_in  input  1  system clock, 25 MHz.
REQ-007 rst_in  input  1  reset, asynchronous, active-high.
REQ-008 key_n  input  N_KEYS  raw button levels, active-low (0 = pressed), asynchronous to clk_in.
REQ-009 key_state  output  N_KEYS  debounced level per key, 1 = pressed.
REQ-010 key_pulse  output  N_KEYS  one-cycle strobe per accepted press.
REQ-011 key_long  output  N_KEYS  one-cycle strobe when the long-press threshold is reached.
REQ-012 key_rep  output  N_KEYS  one-cycle auto-repeat strobe while long-held.

Function
REQ-013 Each key_n bit SHALL pass a 2-flop synchronizer (reset value 1); s[i] = inverted synchronizer output.
REQ-014 One shared free-running counter 0..TICK_CYC-1 SHALL produce a one-cycle tick at count TICK_CYC-1, then wrap to 0.
REQ-015 Each key SHALL own a 16-bit tick counter cnt, a long_flag bit, and an FSM: IDLE, PRESS_DEB, HELD, LONG, REL_DEB.
REQ-016 IDLE: on s=1, go to PRESS_DEB with cnt=0.
REQ-017 PRESS_DEB: on s=0, return to IDLE with no strobe (bounce rejected); on each tick cnt+1; when cnt reaches DEB_MS with s=1, go to HELD, cnt=0, long_flag=0.
REQ-018 HELD: on s=0, go to REL_DEB with cnt=0; on each tick cnt+1; when cnt reaches LONG_MS, go to LONG, cnt=0, long_flag=1.
REQ-019 LONG: on s=0, go to REL_DEB with cnt=0; on each tick cnt+1; when REP_MS≠0 and cnt reaches REP_MS, issue key_rep and set cnt=0.
REQ-020 REL_DEB: on s=1, return to HELD (long_flag=0) or LONG (long_flag=1) with cnt=0 and no strobe; on each tick cnt+1; when cnt reaches DEB_MS with s=0, go to IDLE.
REQ-021 key_state[i] SHALL be 1 in HELD, LONG and REL_DEB, else 0; registered.
REQ-022 key_pulse/key_long/key_rep SHALL be registered and high exactly one cycle, on the cycle key_state/FSM first shows the new state.
REQ-023 Press-to-key_pulse latency SHALL be 2 sync cycles plus DEB_MS ticks (tick-quantized, so between (DEB_MS-1)*TICK_CYC and DEB_MS*TICK_CYC+3 cycles).
REQ-024 Channels SHALL be fully independent; simultaneous presses on several keys SHALL produce same-cycle strobes where their timing coincides.
REQ-025 A level change and a tick in the same cycle: the level change wins (cnt restarts, no increment).
REQ-026 cnt SHALL never wrap: it saturates at 65535 in any state.
REQ-027 key_long SHALL fire at most once per press; key_rep SHALL never fire before key_long in the same press.

Reset
REQ-028 rst_in high SHALL immediately force all FSMs to IDLE, cnt=0, long_flag=0, tick counter=0, synchronizers=1, and all outputs to 0, independent of clk_in.
REQ-029 After rst_in falls with a key still held, that key SHALL re-debounce from IDLE and issue a fresh key_pulse.
REQ-030 No strobe SHALL be issued during the cycle rst_in deasserts.

Verification
Bench uses TICK_CYC=4, DEB_MS=3, LONG_MS=10, REP_MS=4, N_KEYS=3.
REQ-031 Reset: rst_in high, key_n=3'b000 -> key_state, key_pulse, key_long, key_rep all 0.
REQ-032 Clean press: key_n[0] low for 8 ticks, then high -> one key_pulse[0]; key_state[0] high for ~5 ticks plus the release debounce; no key_long.
REQ-033 Bounce: key_n[1] low 2 ticks, high 1 tick, low 2 ticks, then high -> no strobes; key_state[1] stays 0.
REQ-034 Long hold: key_n[2] low for 30 ticks -> exactly 1 key_pulse[2], 1 key_long[2] about 13 ticks after the press, then 4 key_rep[2] spaced 16 cycles apart.
REQ-035 Release glitch: while HELD, key_n[0] high 1 tick then low -> key_state[0] stays 1; no new key_pulse.
REQ-036 Reset mid-operation: rst_in pulsed while key 2 is LONG with key held -> outputs drop to 0 at once; after release, key_pulse[2] about 3 ticks later.
